// File: rtl/clk_gate_pkg.sv
// Shared definitions for the clock-gate enable controller: state encoding and defaults.
package clk_gate_pkg;

    typedef enum logic [1:0] {
        StRun   = 2'b00,
        StGated = 2'b01,
        StWake  = 2'b10
    } state_e;

    localparam int unsigned IDLE_W_DEF   = 4;
    localparam int unsigned WAKE_LAT_DEF = 2;

endpackage

// File: rtl/clk_gate_idle_cnt.sv
// Saturating idle-cycle counter with clear, increment and a live >= threshold compare.
module clk_gate_idle_cnt
    import clk_gate_pkg::*;
#(
    parameter int unsigned IDLE_W = IDLE_W_DEF
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_clr,
    input  logic              i_inc,
    input  logic [IDLE_W-1:0] i_thresh,
    output logic [IDLE_W-1:0] o_cnt,
    output logic              o_at_thresh
);

    logic [IDLE_W-1:0] r_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_inc && (r_cnt != {IDLE_W{1'b1}})) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_cnt       = r_cnt;
    // >= rather than == so a threshold lowered below the count still gates
    assign o_at_thresh = (r_cnt >= i_thresh);

endmodule

// File: rtl/clk_gate_en_ctrl.sv
// Registered E-pin driver for a latch-based clock gate: idle-timeout gating, wake warm-up and
// 4-phase wake_req/wake_ack handshake, all on the free-running clock.
module clk_gate_en_ctrl
    import clk_gate_pkg::*;
#(
    parameter int unsigned IDLE_W   = IDLE_W_DEF,
    parameter int unsigned WAKE_LAT = WAKE_LAT_DEF
) (
    input  logic              forever_cpuclk,
    input  logic              cpurst_b,
    input  logic              gate_dis,
    input  logic              busy,
    input  logic              wake_req,
    input  logic [IDLE_W-1:0] idle_thresh,
    output logic              clk_en,
    output logic              wake_ack,
    output logic              gated
);

    localparam int unsigned         WAKE_CW   = (WAKE_LAT > 1) ? $clog2(WAKE_LAT) : 1;
    localparam logic [WAKE_CW-1:0] WAKE_LAST = WAKE_CW'(WAKE_LAT - 1);

    state_e             r_state;
    logic [WAKE_CW-1:0] r_wake_cnt;
    logic               r_clk_en;
    logic               r_wake_ack;
    logic               r_gated;

    logic               w_idle;
    logic               w_run_idle;
    logic               w_at_thresh;
    logic [IDLE_W-1:0]  w_idle_cnt;

    assign w_idle     = !busy && !wake_req && !gate_dis;
    assign w_run_idle = (r_state == StRun) && w_idle;

    // Outside RUN the count is held at zero so RUN is always re-entered with a fresh count
    clk_gate_idle_cnt #(
        .IDLE_W (IDLE_W)
    ) u_idle_cnt (
        .i_clk       (forever_cpuclk),
        .i_rst_n     (cpurst_b),
        .i_clr       (!w_run_idle),
        .i_inc       (w_run_idle),
        .i_thresh    (idle_thresh),
        .o_cnt       (w_idle_cnt),
        .o_at_thresh (w_at_thresh)
    );

    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            r_state    <= StRun;
            r_wake_cnt <= '0;
            r_clk_en   <= 1'b1;
            r_gated    <= 1'b0;
        end else begin
            unique case (r_state)
                StRun: begin
                    if (w_idle && w_at_thresh) begin
                        r_state  <= StGated;
                        r_clk_en <= 1'b0;
                        r_gated  <= 1'b1;
                    end
                end
                StGated: begin
                    if (wake_req || gate_dis) begin
                        r_state    <= StWake;
                        r_wake_cnt <= '0;
                        r_clk_en   <= 1'b1;
                        r_gated    <= 1'b0;
                    end
                end
                StWake: begin
                    if (r_wake_cnt == WAKE_LAST) begin
                        r_state <= StRun;
                    end else begin
                        r_wake_cnt <= r_wake_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state  <= StRun;
                    r_clk_en <= 1'b1;
                    r_gated  <= 1'b0;
                end
            endcase
        end
    end

    // Ack only once the clock is running in RUN; requests seen in GATED/WAKE wait for warm-up
    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            r_wake_ack <= 1'b0;
        end else if (!wake_req) begin
            r_wake_ack <= 1'b0;
        end else if (r_state == StRun) begin
            r_wake_ack <= 1'b1;
        end
    end

    assign clk_en   = r_clk_en;
    assign wake_ack = r_wake_ack;
    assign gated    = r_gated;

endmodule

// File: tb/tb_clk_gate_en_ctrl.sv
// Scoreboard bench for clk_gate_en_ctrl: directed vectors push expected outputs, a negedge
// monitor pops and compares them against the registered outputs.
module tb_clk_gate_en_ctrl;

    logic       forever_cpuclk = 1'b0;
    logic       cpurst_b       = 1'b1;
    logic       gate_dis       = 1'b0;
    logic       busy           = 1'b1;
    logic       wake_req       = 1'b0;
    logic [3:0] idle_thresh    = 4'd3;
    logic       clk_en;
    logic       wake_ack;
    logic       gated;

    typedef struct {
        int          cyc;
        logic [95:0] name;
        logic        en;
        logic        ack;
        logic        g;
    } exp_t;

    exp_t q[$];
    int   cyc    = 0;
    int   n_vec  = 0;
    int   n_err  = 0;

    clk_gate_en_ctrl #(
        .IDLE_W   (4),
        .WAKE_LAT (2)
    ) dut (
        .forever_cpuclk (forever_cpuclk),
        .cpurst_b       (cpurst_b),
        .gate_dis       (gate_dis),
        .busy           (busy),
        .wake_req       (wake_req),
        .idle_thresh    (idle_thresh),
        .clk_en         (clk_en),
        .wake_ack       (wake_ack),
        .gated          (gated)
    );

    always #5 forever_cpuclk = ~forever_cpuclk;

    always @(posedge forever_cpuclk) cyc <= cyc + 1;

    always @(negedge forever_cpuclk) begin
        exp_t e;
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            e = q.pop_front();
            n_vec++;
            if (e.cyc != cyc || {clk_en, wake_ack, gated} !== {e.en, e.ack, e.g}) begin
                n_err++;
                $display("FAIL %s @cyc %0d (due %0d): en/ack/gated got %b%b%b want %b%b%b",
                         e.name, cyc, e.cyc, clk_en, wake_ack, gated, e.en, e.ack, e.g);
            end
        end
    end

    task automatic push(input logic [95:0] nm, input int c, input logic en, ack, g);
        exp_t e;
        e.cyc  = c;
        e.name = nm;
        e.en   = en;
        e.ack  = ack;
        e.g    = g;
        q.push_back(e);
    endtask

    // Drive one cycle of inputs; expected outputs appear after the edge that samples them
    task automatic vec(input logic [95:0] nm, input logic b, wr, gd, input logic [3:0] th,
                       input logic en, ack, g);
        @(posedge forever_cpuclk);
        #1;
        busy        = b;
        wake_req    = wr;
        gate_dis    = gd;
        idle_thresh = th;
        push(nm, cyc + 1, en, ack, g);
    endtask

    initial begin
        #2;
        cpurst_b = 1'b0;
        push("rst_init", cyc + 1, 1'b1, 1'b0, 1'b0);
        @(posedge forever_cpuclk);
        @(posedge forever_cpuclk);
        #3;
        cpurst_b = 1'b1;

        vec("run_busy",   1, 0, 0, 3,  1, 0, 0);
        // idle timeout with thresh=3: gate on the 4th idle cycle
        vec("t2_idle1",   0, 0, 0, 3,  1, 0, 0);
        vec("t2_idle2",   0, 0, 0, 3,  1, 0, 0);
        vec("t2_idle3",   0, 0, 0, 3,  1, 0, 0);
        vec("t2_gate",    0, 0, 0, 3,  0, 0, 1);
        vec("t2_hold",    0, 0, 0, 3,  0, 0, 1);
        vec("t2_busyign", 1, 0, 0, 3,  0, 0, 1);

        // asynchronous reset while gated, checked before any further clock edge
        @(posedge forever_cpuclk);
        @(posedge forever_cpuclk);
        #3;
        cpurst_b = 1'b0;
        push("t1_rst_async", cyc, 1'b1, 1'b0, 1'b0);
        @(posedge forever_cpuclk);
        #3;
        cpurst_b = 1'b1;
        vec("t1_run",     1, 0, 0, 3,  1, 0, 0);

        vec("t3_th0",     0, 0, 0, 0,  0, 0, 1);

        // wake from GATED: two WAKE cycles, RUN, then ack
        vec("t4_wake0",   0, 1, 0, 0,  1, 0, 0);
        vec("t4_wake1",   0, 1, 0, 0,  1, 0, 0);
        vec("t4_run",     0, 1, 0, 0,  1, 0, 0);
        vec("t4_ack",     0, 1, 0, 0,  1, 1, 0);
        vec("t4_hold",    0, 1, 0, 0,  1, 1, 0);
        vec("t4_drop",    1, 0, 0, 0,  1, 0, 0);

        vec("t3_i0",      0, 0, 0, 3,  1, 0, 0);
        vec("t3_i1",      0, 0, 0, 3,  1, 0, 0);
        vec("t3_busy",    1, 0, 0, 3,  1, 0, 0);
        vec("t3_r0",      0, 0, 0, 3,  1, 0, 0);
        vec("t3_r1",      0, 0, 0, 3,  1, 0, 0);
        vec("t3_r2",      0, 0, 0, 3,  1, 0, 0);
        vec("t3_gate",    0, 0, 0, 3,  0, 0, 1);

        vec("t5_wake",    0, 0, 1, 3,  1, 0, 0);
        vec("t5_w1",      0, 0, 1, 3,  1, 0, 0);
        vec("t5_run",     0, 0, 1, 3,  1, 0, 0);
        vec("t5_nogate0", 0, 0, 1, 3,  1, 0, 0);
        vec("t5_nogate1", 0, 0, 1, 3,  1, 0, 0);
        vec("t5_i0",      0, 0, 0, 2,  1, 0, 0);
        vec("t5_i1",      0, 0, 0, 2,  1, 0, 0);
        vec("t5_gate",    0, 0, 0, 2,  0, 0, 1);

        vec("t6_both",    0, 1, 1, 2,  1, 0, 0);
        vec("t6_w1",      0, 1, 0, 2,  1, 0, 0);
        vec("t6_run",     0, 1, 0, 2,  1, 0, 0);
        vec("t6_ack",     0, 1, 0, 2,  1, 1, 0);
        vec("t6_drop",    1, 0, 0, 2,  1, 0, 0);

        // wake_req lands on the threshold cycle: no gating, ack on the next edge
        vec("t6_i0",      0, 0, 0, 2,  1, 0, 0);
        vec("t6_i1",      0, 0, 0, 2,  1, 0, 0);
        vec("t6_hit",     0, 1, 0, 2,  1, 1, 0);
        vec("t6_hold",    0, 1, 0, 2,  1, 1, 0);
        vec("t6_drop2",   1, 0, 0, 2,  1, 0, 0);

        vec("t6_c1",      0, 0, 0, 7,  1, 0, 0);
        vec("t6_c2",      0, 0, 0, 7,  1, 0, 0);
        vec("t6_c3",      0, 0, 0, 7,  1, 0, 0);
        vec("t6_c4",      0, 0, 0, 7,  1, 0, 0);
        vec("t6_lower",   0, 0, 0, 1,  0, 0, 1);

        repeat (3) @(posedge forever_cpuclk);
        #6;
        n_vec++;
        if (q.size() != 0) begin
            n_err++;
            $display("FAIL sb_drain: %0d expectations left, want 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
